// File: rtl/serial_or_pkg.sv
// Shared types and constants for the serial OR reducer.
// Optional feature macro: SERIAL_OR_ONES_CNT_EN (adds out_ones counter).
package serial_or_pkg;

    localparam int unsigned MAX_LEN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_or_pkg

// File: rtl/serial_or_reducer_if.sv
// Beat-in / frame-result-out handshake bundle for the serial OR reducer.
// Optional feature macro: SERIAL_OR_ONES_CNT_EN (adds out_ones).
interface serial_or_reducer_if
    import serial_or_pkg::*;
#(
    parameter int unsigned LEN_W = $clog2(MAX_LEN_DEF + 1)
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_or;
    logic [LEN_W-1:0] out_len;
    logic             out_ovf;
`ifdef SERIAL_OR_ONES_CNT_EN
    logic [LEN_W-1:0] out_ones;
`endif

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, in_bit, in_last, out_ready,
`ifdef SERIAL_OR_ONES_CNT_EN
        input  out_ones,
`endif
        input  in_ready, out_valid, out_or, out_len, out_ovf
    );

    // Reducer side
    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
`ifdef SERIAL_OR_ONES_CNT_EN
        output out_ones,
`endif
        output in_ready, out_valid, out_or, out_len, out_ovf
    );

endinterface : serial_or_reducer_if

// File: rtl/serial_or_reducer_mux2.sv
// Library 2:1 cell mux: y_c = s ? i1 : i0.
module serial_or_reducer_mux2 (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic y_c
);

    // Pure combinational select
    assign y_c = s ? i1 : i0;

endmodule : serial_or_reducer_mux2

// File: rtl/serial_or_reducer.sv
// Serial OR reducer: ORs the bits of a framed beat stream, reports frame
// length (saturated at MAX_LEN) and an overflow flag, one result per frame.
// Optional feature macro: SERIAL_OR_ONES_CNT_EN (adds saturated ones count).
module serial_or_reducer
    import serial_or_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_or_reducer_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic             acc_q, acc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
`ifdef SERIAL_OR_ONES_CNT_EN
    logic [LEN_W-1:0] ones_q, ones_d;
`endif

    logic in_ready_c;
    logic accept_c;
    logic first_c;
    logic acc_base_c;
    logic acc_next_c;

    // Accept whenever no result is held or the held result leaves this cycle
    assign in_ready_c = !valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    // Any beat accepted outside ACCUM opens a new frame
    assign first_c    = (state_q != ACCUM);

    // First-beat select: drop the old accumulator when a frame opens
    serial_or_reducer_mux2 u_mux_first (
        .i0  (acc_q),
        .i1  (1'b0),
        .s   (first_c),
        .y_c (acc_base_c)
    );

    // OR-by-mux: a 1 bit forces the accumulator high
    serial_or_reducer_mux2 u_mux_or (
        .i0  (acc_base_c),
        .i1  (1'b1),
        .s   (bus.in_bit),
        .y_c (acc_next_c)
    );

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            acc_q   <= 1'b0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_OR_ONES_CNT_EN
            ones_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_OR_ONES_CNT_EN
            ones_q  <= ones_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_OR_ONES_CNT_EN
        ones_d  = ones_q;
`endif

        case (state_q)
            IDLE, ACCUM: begin
                if (accept_c) begin
                    state_d = bus.in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (accept_c) begin
                    state_d = bus.in_last ? DONE : ACCUM;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            acc_d = acc_next_c;
            if (first_c) begin
                len_d = LEN_ONE;
                ovf_d = 1'b0;
            end else begin
                len_d = (len_q == LEN_MAX) ? LEN_MAX : LEN_W'(len_q + LEN_ONE);
                ovf_d = ovf_q || (len_q == LEN_MAX);
            end
`ifdef SERIAL_OR_ONES_CNT_EN
            if (first_c) begin
                ones_d = LEN_W'(bus.in_bit);
            end else if (bus.in_bit && (ones_q != LEN_MAX)) begin
                ones_d = LEN_W'(ones_q + LEN_ONE);
            end
`endif
        end

        valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_or    = acc_q;
    assign bus.out_len   = len_q;
    assign bus.out_ovf   = ovf_q;
`ifdef SERIAL_OR_ONES_CNT_EN
    assign bus.out_ones  = ones_q;
`endif

endmodule : serial_or_reducer

// File: tb/tb_serial_or_reducer.sv
// Scoreboard bench for serial_or_reducer (MAX_LEN = 4).
// Honours SERIAL_OR_ONES_CNT_EN for the out_ones field.
module tb_serial_or_reducer;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned LEN_W   = 3;

    typedef struct {
        int e_or;
        int e_len;
        int e_ovf;
        int e_ones;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;

    serial_or_reducer_if #(.LEN_W(LEN_W)) bus ();

    serial_or_reducer #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one beat and hold it until accepted; garbage on idle inputs afterwards
    task automatic send_beat(input logic b, input logic l);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("in_ready_timeout", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b1;
        bus.in_last  = 1'b1;
    endtask

    // Push the expected result, send n beats (bit i = bits[i]), check 1-cycle latency
    task automatic send_frame(input logic [7:0] bits, input int n,
                              input int e_or, input int e_len, input int e_ovf, input int e_ones);
        exp_t e;
        e.e_or = e_or; e.e_len = e_len; e.e_ovf = e_ovf; e.e_ones = e_ones;
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            send_beat(bits[i], (i == n - 1));
        end
        @(negedge clk);
        chk("latency_out_valid", int'(bus.out_valid), 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every released result against the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_has_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("out_or",  int'(bus.out_or),  mon_e.e_or);
                chk("out_len", int'(bus.out_len), mon_e.e_len);
                chk("out_ovf", int'(bus.out_ovf), mon_e.e_ovf);
`ifdef SERIAL_OR_ONES_CNT_EN
                chk("out_ones", int'(bus.out_ones), mon_e.e_ones);
`endif
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_or",    int'(bus.out_or),    0);
        chk("rst_out_len",   int'(bus.out_len),   0);
        chk("rst_out_ovf",   int'(bus.out_ovf),   0);
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0,0,1,0 -> or 1, len 4 (exactly MAX_LEN, no overflow)
        send_frame(8'b0000_0100, 4, 1, 4, 0, 1);
        // single-beat 0 then single-beat 1: no carry-over
        send_frame(8'b0000_0000, 1, 0, 1, 0, 0);
        send_frame(8'b0000_0001, 1, 1, 1, 0, 1);

        // back-pressure: result held 5 cycles, then released alongside a new beat
        bus.out_ready = 1'b0;
        send_frame(8'b0000_0010, 2, 1, 2, 0, 1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready",  int'(bus.in_ready),  0);
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_out_or",    int'(bus.out_or),    1);
            chk("stall_out_len",   int'(bus.out_len),   2);
            chk("stall_out_ovf",   int'(bus.out_ovf),   0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_frame(8'b0000_0000, 2, 0, 2, 0, 0);

        // overflow: 6 zeros with MAX_LEN 4
        send_frame(8'b0000_0000, 6, 0, 4, 1, 0);
        // overflow with all ones, ones count saturates
        send_frame(8'b0001_1111, 5, 1, 4, 1, 4);
        // 1,0,1,1 -> ones 3, len 4
        send_frame(8'b0000_1101, 4, 1, 4, 0, 3);

        // reset mid-frame after two 1 beats
        send_beat(1'b1, 1'b0);
        send_beat(1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_acc", int'(bus.out_or),  1);
        chk("pre_rst_len", int'(bus.out_len), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_out_or",    int'(bus.out_or),    0);
        chk("midrst_out_len",   int'(bus.out_len),   0);
        chk("midrst_out_ovf",   int'(bus.out_ovf),   0);
`ifdef SERIAL_OR_ONES_CNT_EN
        chk("midrst_out_ones",  int'(bus.out_ones),  0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'b0000_0000, 1, 0, 1, 0, 0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_or_reducer
